wc_frame_tx: RTL and testbench

Transmit-side audio framer for the lightpipe link. It derives the bit clock (bclk) and word clock (wc) from the master clock with a phase-accumulator divider, and serialises stereo samples MSB-first onto sdata. Its output format is the one the receive-side dpll locks to, so the pair forms a loopback path. Samples arrive over a valid/ready handshake through a single-entry hold register.

---
 rtl/wc_frame_tx_if.sv | 24 ++
 rtl/wc_frame_tx.sv | 106 ++++++++++
 tb/tb_wc_frame_tx.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wc_frame_tx_if.sv
// Sample-pair handshake between an audio source and the lightpipe transmit framer.
// The source drives valid and the two samples; the framer answers with ready.
interface wc_frame_tx_if #(
   parameter int SAMPLE_W = 24
);
   logic                in_valid;
   logic                in_ready;
   logic [SAMPLE_W-1:0] in_left;
   logic [SAMPLE_W-1:0] in_right;

   modport master (
      output in_valid,
      output in_left,
      output in_right,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_left,
      input  in_right,
      output in_ready
   );
endinterface

// File: rtl/wc_frame_tx.sv
// Transmit-side lightpipe audio framer: phase-accumulator bclk/wc generation and
// MSB-first, left-justified serialisation of stereo samples from a one-entry hold register.
module wc_frame_tx #(
   parameter logic [31:0] PHASE_INC = 32'd48487863,
   parameter int          SAMPLE_W  = 24,
   parameter int          SLOT_W    = 32
) (
   input  logic          mclk,
   input  logic          rst,
   wc_frame_tx_if.slave  in_if,
   output logic          bclk,
   output logic          wc,
   output logic          sdata,
   output logic          frame_start,
   output logic          underrun
);

   localparam int                FRAME_W  = 2 * SLOT_W;
   localparam int                CNT_W    = $clog2(FRAME_W);
   localparam logic [CNT_W-1:0]  SLOT_CNT = CNT_W'(SLOT_W);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_W - 1);

   logic [31:0]         acc;
   logic [32:0]         acc_sum;
   logic                tick;
   logic                fall_tick;
   logic                started;
   logic [CNT_W-1:0]    bit_cnt;
   logic [CNT_W-1:0]    bit_cnt_nxt;
   logic                load;
   logic                accept;
   logic                hold_full;
   logic [SAMPLE_W-1:0] hold_left;
   logic [SAMPLE_W-1:0] hold_right;
   logic [SLOT_W-1:0]   left_slot;
   logic [SLOT_W-1:0]   right_slot;
   logic [FRAME_W-1:0]  frame_word;
   logic [FRAME_W-1:0]  shreg;
   logic [FRAME_W-1:0]  shreg_src;

   // The carry out of the accumulator is the tick; data only moves on ticks that
   // take bclk from 1 to 0. Until the first falling tick after reset no bit has been
   // driven, so that tick is treated as a wrap and loads the first frame.
   always_comb begin
      acc_sum     = {1'b0, acc} + {1'b0, PHASE_INC};
      tick        = acc_sum[32];
      fall_tick   = tick & bclk;
      accept      = in_if.in_valid & ~hold_full;
      bit_cnt_nxt = '0;
      if (started && bit_cnt != LAST_CNT) begin
         bit_cnt_nxt = bit_cnt + CNT_W'(1);
      end
      load        = fall_tick & (bit_cnt_nxt == '0);
      left_slot   = SLOT_W'(hold_left) << (SLOT_W - SAMPLE_W);
      right_slot  = SLOT_W'(hold_right) << (SLOT_W - SAMPLE_W);
      frame_word  = hold_full ? {left_slot, right_slot} : '0;
      shreg_src   = load ? frame_word : shreg;
   end

   assign in_if.in_ready = ~hold_full;

   // A load reads the hold register as it was at the start of the cycle, so an
   // accept landing on the load cycle is kept for the following frame.
   always_ff @(posedge mclk) begin
      if (rst) begin
         acc         <= '0;
         bclk        <= 1'b0;
         wc          <= 1'b0;
         sdata       <= 1'b0;
         bit_cnt     <= '0;
         started     <= 1'b0;
         shreg       <= '0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
         hold_full   <= 1'b0;
         hold_left   <= '0;
         hold_right  <= '0;
      end else begin
         acc         <= acc_sum[31:0];
         frame_start <= 1'b0;
         underrun    <= 1'b0;
         if (tick) begin
            bclk <= ~bclk;
         end
         if (fall_tick) begin
            started <= 1'b1;
            bit_cnt <= bit_cnt_nxt;
            wc      <= (bit_cnt_nxt >= SLOT_CNT);
            sdata   <= shreg_src[FRAME_W-1];
            shreg   <= shreg_src << 1;
            if (load) begin
               frame_start <= 1'b1;
               underrun    <= ~hold_full;
            end
         end
         if (accept) begin
            hold_full  <= 1'b1;
            hold_left  <= in_if.in_left;
            hold_right <= in_if.in_right;
         end else if (load) begin
            hold_full  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wc_frame_tx.sv
// Self-checking bench for wc_frame_tx: an arithmetic carry-count model predicts bclk/wc/frame
// timing, and negedge receivers decode frames that are compared with the samples handed in.
module tb_wc_frame_tx;

   localparam logic [31:0] INC_A = 32'h8000_0000;
   localparam logic [31:0] INC_C = 32'h5555_5555;
   localparam logic [31:0] INC_Z = 32'h0000_0000;
   localparam int          SLOT  = 4;

   typedef struct {
      logic [7:0] word;
      logic [7:0] wcs;
      logic       ur;
   } frame_t;

   logic mclk = 1'b0;
   logic rst  = 1'b1;
   logic bclk_a, wc_a, sdata_a, fs_a, ur_a;
   logic bclk_b, wc_b, sdata_b, fs_b, ur_b;
   logic bclk_c, wc_c, sdata_c, fs_c, ur_c;
   logic bclk_z, wc_z, sdata_z, fs_z, ur_z;

   int     checks   = 0;
   int     failures = 0;
   int     cyc      = 0;
   frame_t rx_a[$];
   frame_t rx_b[$];

   wc_frame_tx_if #(.SAMPLE_W(4)) if_a ();
   wc_frame_tx_if #(.SAMPLE_W(3)) if_b ();
   wc_frame_tx_if #(.SAMPLE_W(4)) if_c ();
   wc_frame_tx_if #(.SAMPLE_W(4)) if_z ();

   wc_frame_tx #(.PHASE_INC(INC_A), .SAMPLE_W(4), .SLOT_W(SLOT)) dut_a (
      .mclk(mclk), .rst(rst), .in_if(if_a), .bclk(bclk_a), .wc(wc_a),
      .sdata(sdata_a), .frame_start(fs_a), .underrun(ur_a));
   wc_frame_tx #(.PHASE_INC(INC_A), .SAMPLE_W(3), .SLOT_W(SLOT)) dut_b (
      .mclk(mclk), .rst(rst), .in_if(if_b), .bclk(bclk_b), .wc(wc_b),
      .sdata(sdata_b), .frame_start(fs_b), .underrun(ur_b));
   wc_frame_tx #(.PHASE_INC(INC_C), .SAMPLE_W(4), .SLOT_W(SLOT)) dut_c (
      .mclk(mclk), .rst(rst), .in_if(if_c), .bclk(bclk_c), .wc(wc_c),
      .sdata(sdata_c), .frame_start(fs_c), .underrun(ur_c));
   wc_frame_tx #(.PHASE_INC(INC_Z), .SAMPLE_W(4), .SLOT_W(SLOT)) dut_z (
      .mclk(mclk), .rst(rst), .in_if(if_z), .bclk(bclk_z), .wc(wc_z),
      .sdata(sdata_z), .frame_start(fs_z), .underrun(ur_z));

   always #5 mclk = ~mclk;

   // Receivers: sample sdata/wc at each bclk rise, starting at a frame_start pulse.
   logic   col_a = 1'b0, prev_a = 1'b0, col_b = 1'b0, prev_b = 1'b0;
   int     nb_a = 0, nb_b = 0;
   frame_t cur_a, cur_b;

   always @(negedge mclk) begin
      if (rst) begin
         col_a = 1'b0; prev_a = 1'b0;
      end else begin
         if (fs_a) begin
            col_a = 1'b1; nb_a = 0; cur_a.word = '0; cur_a.wcs = '0; cur_a.ur = ur_a;
         end
         if (col_a && bclk_a && !prev_a) begin
            cur_a.word = {cur_a.word[6:0], sdata_a};
            cur_a.wcs  = {cur_a.wcs[6:0], wc_a};
            nb_a++;
            if (nb_a == 8) begin rx_a.push_back(cur_a); col_a = 1'b0; end
         end
         prev_a = bclk_a;
      end
   end

   always @(negedge mclk) begin
      if (rst) begin
         col_b = 1'b0; prev_b = 1'b0;
      end else begin
         if (fs_b) begin
            col_b = 1'b1; nb_b = 0; cur_b.word = '0; cur_b.wcs = '0; cur_b.ur = ur_b;
         end
         if (col_b && bclk_b && !prev_b) begin
            cur_b.word = {cur_b.word[6:0], sdata_b};
            cur_b.wcs  = {cur_b.wcs[6:0], wc_b};
            nb_b++;
            if (nb_b == 8) begin rx_b.push_back(cur_b); col_b = 1'b0; end
         end
         prev_b = bclk_b;
      end
   end

   // Number of accumulator carries after n additions starting from zero.
   function automatic longint unsigned carries(input logic [31:0] inc, input int n);
      longint unsigned prod;
      prod = {32'b0, inc} * 64'(n);
      return prod >> 32;
   endfunction

   function automatic logic exp_bclk(input logic [31:0] inc, input int n);
      longint unsigned c;
      c = carries(inc, n);
      return c[0];
   endfunction

   function automatic logic exp_fs(input logic [31:0] inc, input int n);
      longint unsigned c;
      longint unsigned cp;
      if (n < 1) return 1'b0;
      c  = carries(inc, n);
      cp = carries(inc, n - 1);
      if (c == cp || c < 2 || c[0]) return 1'b0;
      return ((c / 2 - 1) % 64'(2 * SLOT)) == 0;
   endfunction

   function automatic logic exp_wc(input logic [31:0] inc, input int n);
      longint unsigned c;
      c = carries(inc, n);
      if (c < 2) return 1'b0;
      return ((c / 2 - 1) % 64'(2 * SLOT)) >= 64'(SLOT);
   endfunction

   task automatic step;
      @(posedge mclk);
      #1;
      cyc++;
   endtask

   task automatic do_reset;
      if_a.in_valid = 1'b0; if_b.in_valid = 1'b0; if_c.in_valid = 1'b0; if_z.in_valid = 1'b0;
      rst = 1'b1;
      step;
      rst = 1'b0;
      cyc = 0;
      rx_a.delete();
      rx_b.delete();
   endtask

   task automatic test_reset;
      do_reset;
      if_a.in_valid = 1'b1; if_a.in_left = 4'($urandom); if_a.in_right = 4'($urandom);
      for (int i = 0; i < 23; i++) step;
      do_reset;
      checks++;
      if ({bclk_a, wc_a, sdata_a, fs_a, ur_a, if_a.in_ready} !== 6'b000001) begin
         failures++;
         $display("[TB] FAIL reset_a got=%b exp=000001", {bclk_a, wc_a, sdata_a, fs_a, ur_a, if_a.in_ready});
      end
      checks++;
      if ({bclk_b, wc_b, sdata_b, fs_b, ur_b, if_b.in_ready} !== 6'b000001) begin
         failures++;
         $display("[TB] FAIL reset_b got=%b exp=000001", {bclk_b, wc_b, sdata_b, fs_b, ur_b, if_b.in_ready});
      end
      checks++;
      if ({bclk_z, wc_z, sdata_z, fs_z, ur_z, if_z.in_ready} !== 6'b000001) begin
         failures++;
         $display("[TB] FAIL reset_z got=%b exp=000001", {bclk_z, wc_z, sdata_z, fs_z, ur_z, if_z.in_ready});
      end
   endtask

   task automatic test_clocking;
      logic [4:0] exp;
      do_reset;
      for (int n = 1; n <= 100; n++) begin
         step;
         exp = {exp_bclk(INC_A, cyc), exp_wc(INC_A, cyc), exp_fs(INC_A, cyc), exp_fs(INC_A, cyc), 1'b0};
         checks++;
         if ({bclk_a, wc_a, fs_a, ur_a, sdata_a} !== exp) begin
            failures++;
            $display("[TB] FAIL clk_a cyc=%0d got=%b exp=%b", cyc, {bclk_a, wc_a, fs_a, ur_a, sdata_a}, exp);
         end
         exp = {exp_bclk(INC_C, cyc), exp_wc(INC_C, cyc), exp_fs(INC_C, cyc), exp_fs(INC_C, cyc), 1'b0};
         checks++;
         if ({bclk_c, wc_c, fs_c, ur_c, sdata_c} !== exp) begin
            failures++;
            $display("[TB] FAIL clk_c cyc=%0d got=%b exp=%b", cyc, {bclk_c, wc_c, fs_c, ur_c, sdata_c}, exp);
         end
         checks++;
         if ({bclk_z, wc_z, fs_z, ur_z, sdata_z} !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL clk_zero_inc cyc=%0d got=%b exp=00000", cyc, {bclk_z, wc_z, fs_z, ur_z, sdata_z});
         end
      end
   endtask

   task automatic test_serialisation;
      do_reset;
      if_a.in_valid = 1'b1; if_a.in_left = 4'hA;   if_a.in_right = 4'h5;
      if_b.in_valid = 1'b1; if_b.in_left = 3'b111; if_b.in_right = 3'b010;
      step;
      checks++;
      if ({if_a.in_ready, if_b.in_ready} !== 2'b00) begin
         failures++;
         $display("[TB] FAIL ser_ready got=%b exp=00", {if_a.in_ready, if_b.in_ready});
      end
      if_a.in_valid = 1'b0; if_a.in_left = 4'($urandom); if_a.in_right = 4'($urandom);
      if_b.in_valid = 1'b0; if_b.in_left = 3'($urandom); if_b.in_right = 3'($urandom);
      for (int i = 0; i < 100 && (rx_a.size() < 1 || rx_b.size() < 1); i++) step;
      checks++;
      if (rx_a.size() < 1 || rx_b.size() < 1) begin
         failures++;
         $display("[TB] FAIL ser_timeout got=%0d/%0d frames exp=1/1", rx_a.size(), rx_b.size());
      end else begin
         checks++;
         if ({rx_a[0].word, rx_a[0].wcs, rx_a[0].ur} !== {8'b1010_0101, 8'b0000_1111, 1'b0}) begin
            failures++;
            $display("[TB] FAIL ser_a got=%b/%b/%b exp=10100101/00001111/0", rx_a[0].word, rx_a[0].wcs, rx_a[0].ur);
         end
         checks++;
         if ({rx_b[0].word, rx_b[0].wcs, rx_b[0].ur} !== {8'b1110_0100, 8'b0000_1111, 1'b0}) begin
            failures++;
            $display("[TB] FAIL pad_b got=%b/%b/%b exp=11100100/00001111/0", rx_b[0].word, rx_b[0].wcs, rx_b[0].ur);
         end
      end
   endtask

   task automatic test_underrun;
      do_reset;
      for (int i = 0; i < 200 && rx_a.size() < 3; i++) begin
         step;
         checks++;
         if (fs_a !== ur_a || sdata_a !== 1'b0) begin
            failures++;
            $display("[TB] FAIL underrun_pulse cyc=%0d got fs/ur/sd=%b%b%b", cyc, fs_a, ur_a, sdata_a);
         end
      end
      checks++;
      if (rx_a.size() < 3) begin
         failures++;
         $display("[TB] FAIL underrun_timeout got=%0d frames exp=3", rx_a.size());
      end
      foreach (rx_a[i]) begin
         checks++;
         if ({rx_a[i].word, rx_a[i].ur} !== {8'h00, 1'b1}) begin
            failures++;
            $display("[TB] FAIL underrun_frame%0d got=%b/%b exp=00000000/1", i, rx_a[i].word, rx_a[i].ur);
         end
      end
   endtask

   task automatic test_handshake;
      logic [7:0] sent_q[$];
      logic       took;
      int         acc_cnt;
      do_reset;
      acc_cnt = 0;
      if_a.in_valid = 1'b1; if_a.in_left = 4'($urandom); if_a.in_right = 4'($urandom);
      for (int i = 0; i < 200; i++) begin
         took = if_a.in_ready;
         step;
         if (took) begin
            sent_q.push_back({if_a.in_left, if_a.in_right});
            acc_cnt++;
            checks++;
            if (if_a.in_ready !== 1'b0) begin
               failures++;
               $display("[TB] FAIL hs_ready_after_accept cyc=%0d got=%b exp=0", cyc, if_a.in_ready);
            end
            if_a.in_left  = if_a.in_left + 4'd1;
            if_a.in_right = 4'($urandom);
         end
         if (fs_a) begin
            checks++;
            if (acc_cnt != 1) begin
               failures++;
               $display("[TB] FAIL hs_accepts_per_frame cyc=%0d got=%0d exp=1", cyc, acc_cnt);
            end
            acc_cnt = 0;
            checks++;
            if (if_a.in_ready !== 1'b1) begin
               failures++;
               $display("[TB] FAIL hs_ready_after_load cyc=%0d got=%b exp=1", cyc, if_a.in_ready);
            end
         end
      end
      if_a.in_valid = 1'b0;
      checks++;
      if (rx_a.size() < 5) begin
         failures++;
         $display("[TB] FAIL hs_frames got=%0d exp>=5", rx_a.size());
      end
      for (int i = 0; i < rx_a.size() && i < sent_q.size(); i++) begin
         checks++;
         if ({rx_a[i].word, rx_a[i].ur} !== {sent_q[i], 1'b0}) begin
            failures++;
            $display("[TB] FAIL hs_seq%0d got=%h/%b exp=%h/0", i, rx_a[i].word, rx_a[i].ur, sent_q[i]);
         end
      end
   endtask

   task automatic test_accept_on_load;
      logic [7:0] s;
      do_reset;
      for (int i = 0; i < 100 && !(exp_fs(INC_A, cyc + 1) && cyc >= 4); i++) step;
      checks++;
      if (if_a.in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL aol_ready_before got=%b exp=1", if_a.in_ready);
      end
      s = 8'($urandom);
      if_a.in_valid = 1'b1; if_a.in_left = s[7:4]; if_a.in_right = s[3:0];
      step;
      if_a.in_valid = 1'b0; if_a.in_left = 4'($urandom); if_a.in_right = 4'($urandom);
      checks++;
      if ({fs_a, ur_a, if_a.in_ready} !== 3'b110) begin
         failures++;
         $display("[TB] FAIL aol_load_cycle cyc=%0d got=%b exp=110", cyc, {fs_a, ur_a, if_a.in_ready});
      end
      for (int i = 0; i < 100 && rx_a.size() < 3; i++) step;
      checks++;
      if (rx_a.size() < 3) begin
         failures++;
         $display("[TB] FAIL aol_timeout got=%0d frames exp=3", rx_a.size());
      end else begin
         checks++;
         if ({rx_a[1].word, rx_a[1].ur} !== {8'h00, 1'b1}) begin
            failures++;
            $display("[TB] FAIL aol_underrun_frame got=%h/%b exp=00/1", rx_a[1].word, rx_a[1].ur);
         end
         checks++;
         if ({rx_a[2].word, rx_a[2].ur} !== {s, 1'b0}) begin
            failures++;
            $display("[TB] FAIL aol_next_frame got=%h/%b exp=%h/0", rx_a[2].word, rx_a[2].ur, s);
         end
      end
   endtask

   task automatic test_midreset;
      do_reset;
      if_a.in_valid = 1'b1; if_a.in_left = 4'($urandom); if_a.in_right = 4'($urandom);
      step;
      if_a.in_valid = 1'b0;
      for (int i = 0; i < 100 && !(exp_wc(INC_A, cyc) && cyc > 4); i++) step;
      checks++;
      if (wc_a !== 1'b1) begin
         failures++;
         $display("[TB] FAIL mr_in_right_slot cyc=%0d got=%b exp=1", cyc, wc_a);
      end
      rst = 1'b1;
      if_a.in_valid = 1'b1;
      step;
      rst = 1'b0;
      if_a.in_valid = 1'b0;
      cyc = 0;
      checks++;
      if ({bclk_a, wc_a, sdata_a, fs_a, ur_a, if_a.in_ready} !== 6'b000001) begin
         failures++;
         $display("[TB] FAIL mr_reset_values got=%b exp=000001", {bclk_a, wc_a, sdata_a, fs_a, ur_a, if_a.in_ready});
      end
      for (int n = 1; n <= 8; n++) begin
         step;
         checks++;
         if ({fs_a, ur_a} !== ((cyc == 4) ? 2'b11 : 2'b00)) begin
            failures++;
            $display("[TB] FAIL mr_first_frame cyc=%0d got=%b exp=%b", cyc, {fs_a, ur_a}, (cyc == 4) ? 2'b11 : 2'b00);
         end
      end
   endtask

   initial begin
      if_a.in_valid = 1'b0; if_a.in_left = '0; if_a.in_right = '0;
      if_b.in_valid = 1'b0; if_b.in_left = '0; if_b.in_right = '0;
      if_c.in_valid = 1'b0; if_c.in_left = '0; if_c.in_right = '0;
      if_z.in_valid = 1'b0; if_z.in_left = '0; if_z.in_right = '0;
      test_reset;
      test_clocking;
      test_serialisation;
      test_underrun;
      test_handshake;
      test_accept_on_load;
      test_midreset;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
